// File: rtl/muldiv_pkg.sv
// Shared definitions for muldiv_unit: op encodings, FSM states and a
// two's-complement helper sized for operands up to 64 bits (products up to 128).
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  // Callers zero-extend into MAX_W bits and truncate the result back down;
  // the low bits of a negation do not depend on the working width.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and muldiv_unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the result if it did not borrow.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;

  always_comb begin
    rem_shift = {rem_in, dividend_bit};
    trial     = {1'b0, rem_shift} - {2'b00, divisor};
    q_bit     = ~trial[WIDTH+1];
    rem_out   = WIDTH'(q_bit ? trial : {1'b0, rem_shift});
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (divide timing unchanged).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);
  localparam int              CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               signed_op, is_muldiv, op_is_div;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  // Divide reuses acc: upper half is the partial remainder, lower half shifts
  // the dividend out while quotient bits shift in.
  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in      (acc_q[2*WIDTH-1:WIDTH]),
    .dividend_bit(acc_q[WIDTH-1]),
    .divisor     (opnd_q),
    .rem_out     (rem_next),
    .q_bit       (q_bit)
  );

  always_comb begin
    signed_op  = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    is_muldiv  = ~bus.op[2];
    op_is_div  = bus.op[1];
    neg_a      = signed_op & bus.a[WIDTH-1];
    neg_b      = signed_op & bus.b[WIDTH-1];
    abs_a      = WIDTH'(cond_neg(MAX_W'(bus.a), neg_a));
    abs_b      = WIDTH'(cond_neg(MAX_W'(bus.b), neg_b));
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    prod_fixed = (2*WIDTH)'(cond_neg(MAX_W'(acc_q), sign_a_q ^ sign_b_q));
    quo_fixed  = WIDTH'(cond_neg(MAX_W'(acc_q[WIDTH-1:0]), sign_a_q ^ sign_b_q));
    rem_fixed  = WIDTH'(cond_neg(MAX_W'(acc_q[2*WIDTH-1:WIDTH]), sign_a_q));
  end

  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    b_zero_d   = b_zero_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          if (is_muldiv) begin
            is_div_d = op_is_div;
            sign_a_d = neg_a;
            sign_b_d = neg_b;
            b_zero_d = (bus.b == '0);
            opnd_d   = op_is_div ? abs_b : abs_a;
            acc_d    = {{WIDTH{1'b0}}, (op_is_div ? abs_a : abs_b)};
            count_d  = '0;
            state_d  = RUN;
`ifdef MULDIV_FAST_MUL_EN
            if (!op_is_div) begin
              acc_d   = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
              state_d = FIX;
            end
`endif
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end

      RUN: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = {rem_next, acc_q[WIDTH-2:0], q_bit};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          count_d = count_q + 1'b1;
          if (count_q == LAST_ITER) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            // A zero divisor leaves |a| as remainder, so hi still reads back as a.
            hi_d       = rem_fixed;
            lo_d       = b_zero_q ? '1 : quo_fixed;
            div_zero_d = b_zero_q;
          end else begin
            {hi_d, lo_d} = prod_fixed;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      b_zero_q   <= b_zero_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
